// File: rtl/remem_issue_queue_if.sv
// Issue-queue bus: CPU-side push handshake, controller-side head/stall, status.
// slave = the queue itself, master = whoever drives the queue (CPU + controller).
interface remem_issue_queue_if #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = $clog2(DEPTH + 1)
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [DATA_W-1:0]  in_data;
  logic               flush;
  logic               stall;
  logic [INSTR_W-1:0] out_instr;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic [CNT_W-1:0]   count;
  logic               err_illegal;

  modport slave (
    input  in_valid, in_instr, in_data, flush, stall,
    output in_ready, out_instr, out_data, out_valid, count, err_illegal
  );

  modport master (
    output in_valid, in_instr, in_data, flush, stall,
    input  in_ready, out_instr, out_data, out_valid, count, err_illegal
  );
endinterface

// File: rtl/remem_issue_queue.sv
// Issue FIFO in front of the memristor memory controller.
// Buffers gate/write/read instructions plus write data; NOPs are swallowed and
// reserved opcodes (3'b1xx) are dropped while raising a sticky error flag.
// The head is held while the controller asserts stall.
// Optional: define REMEM_IQ_BYPASS_EN to let a storable instruction offered to
// an empty queue drive the head combinationally (zero-cycle latency).
module remem_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  remem_issue_queue_if.slave     bus
);
  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  logic [2:0] opc;
  logic       storable, illegal, empty, push, pop, wr_en, byp, byp_take;

  assign opc      = bus.in_instr[INSTR_W-1 -: 3];
  assign storable = (opc == 3'b001) || (opc == 3'b010) || (opc == 3'b011);
  assign illegal  = opc[2];
  assign empty    = (cnt == '0);

  // Ready depends on occupancy alone so the CPU never sees stall ripple through.
  assign bus.in_ready = (cnt < FULL);
  assign push         = bus.in_valid && bus.in_ready;

`ifdef REMEM_IQ_BYPASS_EN
  assign byp = empty && bus.in_valid && storable;
`else
  assign byp = 1'b0;
`endif
  // A bypassed entry taken by the controller this edge never touches storage.
  assign byp_take = byp && !bus.stall;
  assign pop      = !empty && !bus.stall;
  assign wr_en    = push && storable && !bus.flush && !byp_take;

  assign bus.count       = cnt;
  assign bus.err_illegal = err_q;

  // Head presentation: bypass path first, else storage at the read pointer, NOP when empty.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_instr = '0;
    bus.out_data  = '0;
    if (byp) begin
      bus.out_valid = 1'b1;
      bus.out_instr = bus.in_instr;
      bus.out_data  = bus.in_data;
    end else if (!empty) begin
      bus.out_valid = 1'b1;
      bus.out_instr = mem[rd_ptr].instr;
      bus.out_data  = mem[rd_ptr].data;
    end
  end

  // Pointer and occupancy bookkeeping; flush beats push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky illegal-opcode flag; a flush does not hide a bad offer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  err_q <= 1'b0;
    else if (push && illegal) err_q <= 1'b1;
  end

  // Entry storage, no reset needed since contents are qualified by count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {bus.in_instr, bus.in_data};
  end
endmodule
